// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : UART transmitter with write FIFO, parametrised frame format
// Revision 1.0 : initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_BITS-1:0]            data,
    input  logic                            en_tx,
    input  logic                            en,
    input  logic                            clr_ovf,
    output logic                            tbr,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt,
    output logic                            ovf,
    output logic                            TxD
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_cnt;
    logic                 r_ovf;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic                 r_txd;
    logic                 w_txd_nxt;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic                 r_stop;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_par;

    logic                 w_full;
    logic                 w_nempty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_head;

    assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
    assign w_nempty  = (r_cnt != '0);
    assign w_push    = en_tx & ~w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = en & (r_tick == TW'(OVERSAMPLE - 1));

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            // An overflowing write in the same cycle as a clear keeps the flag set
            if (en_tx && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------- FSM: state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // ----------------------------------------------------- FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nempty) begin
                    w_state_nxt = S_START;
                    w_pop       = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit == BW'(DATA_BITS - 1))) begin
                    w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end && (r_stop == 1'(STOP_BITS - 1))) begin
                    if (w_nempty) begin
                        w_state_nxt = S_START;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // --------------------------------------------------------- FSM: output
    // TxD is decoded from the next state so the line level tracks the state register
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_pop) begin
            w_shift_nxt = w_head;
        end else if ((r_state == S_DATA) && w_bit_end) begin
            w_shift_nxt = r_shift >> 1;
        end
        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[0];
            S_PARITY: w_txd_nxt = r_par;
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            if (w_pop) begin
                r_tick <= '0;
                r_par  <= (^w_head) ^ (PARITY_ODD != 0);
            end else if ((r_state != S_IDLE) && en) begin
                r_tick <= w_bit_end ? '0 : r_tick + TW'(1);
            end
            if ((r_state == S_START) && w_bit_end) begin
                r_bit <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_bit <= r_bit + BW'(1);
            end
            if ((w_state_nxt == S_STOP) && (r_state != S_STOP)) begin
                r_stop <= 1'b0;
            end else if ((r_state == S_STOP) && w_bit_end) begin
                r_stop <= r_stop + 1'b1;
            end
        end
    end

    assign tbr      = ~w_full;
    assign tx_busy  = (r_state != S_IDLE) | w_nempty;
    assign fifo_cnt = r_cnt;
    assign ovf      = r_ovf;
    assign TxD      = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo : three configurations of uart_tx_fifo against a frame model
// Revision 1.0 : initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_tx;
    logic       en;
    logic       clr_ovf;
    logic [7:0] data;

    logic [2:0] txd_o, tbr_o, busy_o, ovf_o;
    logic [2:0] cnt0, cnt1;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    // 8N1, depth 4
    uart_tx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .data(data), .en_tx(en_tx), .en(en), .clr_ovf(clr_ovf),
        .tbr(tbr_o[0]), .tx_busy(busy_o[0]), .fifo_cnt(cnt0), .ovf(ovf_o[0]), .TxD(txd_o[0]));

    // 8E2, depth 4
    uart_tx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .data(data), .en_tx(en_tx), .en(en), .clr_ovf(clr_ovf),
        .tbr(tbr_o[1]), .tx_busy(busy_o[1]), .fifo_cnt(cnt1), .ovf(ovf_o[1]), .TxD(txd_o[1]));

    // 7O1, oversample 4, depth 2
    uart_tx_fifo #(.DATA_BITS(7), .OVERSAMPLE(4), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(1), .FIFO_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .data(data[6:0]), .en_tx(en_tx), .en(en), .clr_ovf(clr_ovf),
        .tbr(tbr_o[2]), .tx_busy(busy_o[2]), .fifo_cnt(cnt2), .ovf(ovf_o[2]), .TxD(txd_o[2]));

    int cfg_db [3] = '{8, 8, 7};
    int cfg_os [3] = '{16, 16, 4};
    int cfg_pe [3] = '{0, 1, 1};
    int cfg_po [3] = '{0, 0, 1};
    int cfg_sb [3] = '{1, 2, 1};
    int cfg_dp [3] = '{4, 4, 2};

    // Reference: pending words, plus the current frame as an explicit list of line levels
    int mq     [3][$];
    bit m_in   [3];
    int m_pos  [3];
    int m_tick [3];
    int m_len  [3];
    int m_bits [3][16];
    bit m_ovf  [3];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic start_frame(input int k, input int w);
        int n    = 0;
        int ones = 0;
        m_bits[k][n] = 0;
        n++;
        for (int i = 0; i < cfg_db[k]; i++) begin
            m_bits[k][n] = (w >> i) & 1;
            ones += m_bits[k][n];
            n++;
        end
        if (cfg_pe[k] != 0) begin
            m_bits[k][n] = (ones % 2) ^ cfg_po[k];
            n++;
        end
        for (int s = 0; s < cfg_sb[k]; s++) begin
            m_bits[k][n] = 1;
            n++;
        end
        m_len[k]  = n;
        m_in[k]   = 1'b1;
        m_pos[k]  = 0;
        m_tick[k] = 0;
    endtask

    task automatic model_step();
        bit full;
        bit start;
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                mq[k].delete();
                m_in[k]   = 1'b0;
                m_pos[k]  = 0;
                m_tick[k] = 0;
                m_ovf[k]  = 1'b0;
            end else begin
                full  = (mq[k].size() == cfg_dp[k]);
                start = 1'b0;
                if (!m_in[k]) begin
                    start = (mq[k].size() > 0);
                end else if (en) begin
                    m_tick[k]++;
                    if (m_tick[k] == cfg_os[k]) begin
                        m_tick[k] = 0;
                        m_pos[k]++;
                        if (m_pos[k] == m_len[k]) begin
                            m_in[k] = 1'b0;
                            start   = (mq[k].size() > 0);
                        end
                    end
                end
                if (start) begin
                    start_frame(k, mq[k].pop_front());
                end
                if (en_tx && !full) begin
                    mq[k].push_back(int'(data) & ((1 << cfg_db[k]) - 1));
                end
                if (en_tx && full) begin
                    m_ovf[k] = 1'b1;
                end else if (clr_ovf) begin
                    m_ovf[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        int cnt_obs;
        int cnt_exp;
        for (int k = 0; k < 3; k++) begin
            cnt_obs = (k == 0) ? int'(cnt0) : (k == 1) ? int'(cnt1) : int'(cnt2);
            cnt_exp = mq[k].size();
            chk_eq($sformatf("txd%0d", k),  int'(txd_o[k]),  m_in[k] ? m_bits[k][m_pos[k]] : 1);
            chk_eq($sformatf("cnt%0d", k),  cnt_obs,         cnt_exp);
            chk_eq($sformatf("tbr%0d", k),  int'(tbr_o[k]),  int'(cnt_exp != cfg_dp[k]));
            chk_eq($sformatf("busy%0d", k), int'(busy_o[k]), int'(m_in[k] || cnt_exp != 0));
            chk_eq($sformatf("ovf%0d", k),  int'(ovf_o[k]),  int'(m_ovf[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] v);
        data  = v;
        en_tx = 1'b1;
        cycle();
        en_tx = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_in[k]  = 1'b0;
            m_ovf[k] = 1'b0;
        end
        rst     = 1'b0;
        en      = 1'b1;
        en_tx   = 1'b1;
        clr_ovf = 1'b0;
        data    = 8'hFF;
        @(negedge clk);

        // Writes during reset must be ignored
        repeat (3) cycle();
        rst   = 1'b1;
        en_tx = 1'b0;
        repeat (5) cycle();

        // Single frames with en held high
        send(8'hA5);
        repeat (200) cycle();
        send(8'h07);
        repeat (200) cycle();

        // Fill and overflow with the baud tick stopped
        en = 1'b0;
        for (int v = 1; v <= 5; v++) send(8'(v));
        repeat (3) cycle();
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        cycle();
        en_tx   = 1'b1;
        clr_ovf = 1'b1;
        data    = 8'h66;
        cycle();
        en_tx   = 1'b0;
        clr_ovf = 1'b0;
        cycle();
        en = 1'b1;
        repeat (850) cycle();
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;

        // Sparse baud tick: one en every 7 clocks
        data = 8'h3C;
        for (int i = 0; i < 1400; i++) begin
            en    = ((i % 7) == 0);
            en_tx = (i == 0);
            cycle();
        end
        en_tx = 1'b0;
        en    = 1'b1;

        // Reset in the middle of data bit 3 with further words queued
        for (int i = 0; i < 3; i++) send(8'($urandom));
        repeat (16 * 4 + 6) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        repeat (250) cycle();

        // Random traffic, random baud gaps, occasional resets
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 1) == 1);
            en_tx   = ($urandom_range(0, 19) == 0);
            clr_ovf = ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 999) != 0);
            data    = 8'($urandom);
            cycle();
        end
        rst     = 1'b1;
        en      = 1'b1;
        en_tx   = 1'b0;
        clr_ovf = 1'b0;
        repeat (900) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
